// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - two-port register-file writeback arbiter for two issue lanes plus MD/LD aux sources
// Optional statistics outputs are built when WB_ARB_STATS_EN is defined.
module wb_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            l0_valid,
    input  logic [4:0]      l0_rd,
    input  logic [XLEN-1:0] l0_data,
    input  logic            l1_valid,
    input  logic [4:0]      l1_rd,
    input  logic [XLEN-1:0] l1_data,
    input  logic            md_valid,
    input  logic [4:0]      md_rd,
    input  logic [XLEN-1:0] md_data,
    output logic            md_ready,
    input  logic            ld_valid,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            ld_ready,
    output logic            wb_stall,
    output logic            rf_we0,
    output logic            rf_we1,
    output logic [4:0]      rf_waddr0,
    output logic [4:0]      rf_waddr1,
    output logic [XLEN-1:0] rf_wdata0,
    output logic [XLEN-1:0] rf_wdata1
`ifdef WB_ARB_STATS_EN
    ,
    output logic [31:0]     stat_stall_cycles,
    output logic [31:0]     stat_aux_wait_cycles,
    output logic [31:0]     stat_x0_drops
`endif
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    // Aux index 0 is MD, 1 is LD; rr_ptr names the aux served first.
    logic            rr_ptr;
    logic            rr_ptr_d;
    logic [7:0]      md_wait;
    logic [7:0]      ld_wait;
    logic [7:0]      md_wait_d;
    logic [7:0]      ld_wait_d;
    logic            stall_d;

    logic            l0_acc;
    logic            l1_acc;
    logic            l0_we;
    logic [1:0]      used;
    logic            idx;
    logic            lane_hit;
    logic            pair_hit;
    logic [1:0]      aux_gnt;

    logic            aux_valid [2];
    logic [4:0]      aux_rd    [2];
    logic [XLEN-1:0] aux_data  [2];

    logic            port_gnt  [2];
    logic            port_we   [2];
    logic [4:0]      port_addr [2];
    logic [XLEN-1:0] port_data [2];

    assign aux_valid[0] = md_valid;
    assign aux_valid[1] = ld_valid;
    assign aux_rd[0]    = md_rd;
    assign aux_rd[1]    = ld_rd;
    assign aux_data[0]  = md_data;
    assign aux_data[1]  = ld_data;

    assign md_ready = aux_gnt[0];
    assign ld_ready = aux_gnt[1];

    always_comb begin
        port_gnt  = '{default: 1'b0};
        port_we   = '{default: 1'b0};
        port_addr = '{default: '0};
        port_data = '{default: '0};
        aux_gnt   = 2'b00;
        used      = 2'd0;
        idx       = 1'b0;
        lane_hit  = 1'b0;
        pair_hit  = 1'b0;

        l0_acc = l0_valid && !wb_stall;
        l1_acc = l1_valid && !wb_stall;
        // Younger lane wins a same-rd collision; l0 still occupies its port.
        l0_we  = (l0_rd != 5'd0) && !(l1_acc && (l1_rd == l0_rd));

        if (l0_acc) begin
            port_gnt[0]  = 1'b1;
            port_we[0]   = l0_we;
            port_addr[0] = l0_rd;
            port_data[0] = l0_data;
            used         = 2'd1;
        end

        if (l1_acc) begin
            port_gnt[used[0]]  = 1'b1;
            port_we[used[0]]   = (l1_rd != 5'd0);
            port_addr[used[0]] = l1_rd;
            port_data[used[0]] = l1_data;
            used               = used + 2'd1;
        end

        for (int k = 0; k < 2; k++) begin
            idx      = (k == 0) ? rr_ptr : ~rr_ptr;
            lane_hit = (aux_rd[idx] != 5'd0) &&
                       ((l0_acc && (l0_rd == aux_rd[idx])) ||
                        (l1_acc && (l1_rd == aux_rd[idx])));
            pair_hit = (k == 1) && aux_gnt[rr_ptr] && (aux_rd[idx] != 5'd0) &&
                       (aux_rd[idx] == aux_rd[rr_ptr]);
            if (aux_valid[idx] && !lane_hit && !pair_hit && (used < 2'd2)) begin
                aux_gnt[idx]       = 1'b1;
                port_gnt[used[0]]  = 1'b1;
                port_we[used[0]]   = (aux_rd[idx] != 5'd0);
                port_addr[used[0]] = aux_rd[idx];
                port_data[used[0]] = aux_data[idx];
                used               = used + 2'd1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr;
        if (aux_gnt == 2'b01) begin
            rr_ptr_d = 1'b1;
        end else if (aux_gnt == 2'b10) begin
            rr_ptr_d = 1'b0;
        end else if (aux_gnt == 2'b11) begin
            rr_ptr_d = ~rr_ptr;
        end

        md_wait_d = 8'd0;
        if (md_valid && !aux_gnt[0]) begin
            md_wait_d = (md_wait == LIMIT) ? LIMIT : md_wait + 8'd1;
        end
        ld_wait_d = 8'd0;
        if (ld_valid && !aux_gnt[1]) begin
            ld_wait_d = (ld_wait == LIMIT) ? LIMIT : ld_wait + 8'd1;
        end

        // Evaluated on post-grant counts so a served stall cycle releases next cycle.
        stall_d = (md_wait_d == LIMIT) || (ld_wait_d == LIMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= 1'b0;
            md_wait   <= 8'd0;
            ld_wait   <= 8'd0;
            wb_stall  <= 1'b0;
            rf_we0    <= 1'b0;
            rf_we1    <= 1'b0;
            rf_waddr0 <= 5'd0;
            rf_waddr1 <= 5'd0;
            rf_wdata0 <= '0;
            rf_wdata1 <= '0;
        end else begin
            rr_ptr   <= rr_ptr_d;
            md_wait  <= md_wait_d;
            ld_wait  <= ld_wait_d;
            wb_stall <= stall_d;
            rf_we0   <= port_gnt[0] && port_we[0];
            rf_we1   <= port_gnt[1] && port_we[1];
            if (port_gnt[0]) begin
                rf_waddr0 <= port_addr[0];
                rf_wdata0 <= port_data[0];
            end
            if (port_gnt[1]) begin
                rf_waddr1 <= port_addr[1];
                rf_wdata1 <= port_data[1];
            end
        end
    end

`ifdef WB_ARB_STATS_EN
    logic       aux_waiting;
    logic [1:0] x0_count;

    assign aux_waiting = (md_valid && !md_ready) || (ld_valid && !ld_ready);
    assign x0_count    = {1'b0, port_gnt[0] && (port_addr[0] == 5'd0)} +
                         {1'b0, port_gnt[1] && (port_addr[1] == 5'd0)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_stall_cycles    <= 32'd0;
            stat_aux_wait_cycles <= 32'd0;
            stat_x0_drops        <= 32'd0;
        end else begin
            if (wb_stall) begin
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            end
            if (aux_waiting) begin
                stat_aux_wait_cycles <= stat_aux_wait_cycles + 32'd1;
            end
            stat_x0_drops <= stat_x0_drops + {30'd0, x0_count};
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        l0_valid, l1_valid, md_valid, ld_valid;
    logic [4:0]  l0_rd, l1_rd, md_rd, ld_rd;
    logic [31:0] l0_data, l1_data, md_data, ld_data;
    logic        md_ready, ld_ready, wb_stall;
    logic        rf_we0, rf_we1;
    logic [4:0]  rf_waddr0, rf_waddr1;
    logic [31:0] rf_wdata0, rf_wdata1;
`ifdef WB_ARB_STATS_EN
    logic [31:0] stat_stall_cycles, stat_aux_wait_cycles, stat_x0_drops;
`endif

    int total = 0;
    int bad   = 0;

    wb_port_arbiter #(.XLEN(32), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .l0_valid(l0_valid), .l0_rd(l0_rd), .l0_data(l0_data),
        .l1_valid(l1_valid), .l1_rd(l1_rd), .l1_data(l1_data),
        .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .wb_stall(wb_stall),
        .rf_we0(rf_we0), .rf_we1(rf_we1),
        .rf_waddr0(rf_waddr0), .rf_waddr1(rf_waddr1),
        .rf_wdata0(rf_wdata0), .rf_wdata1(rf_wdata1)
`ifdef WB_ARB_STATS_EN
        ,
        .stat_stall_cycles(stat_stall_cycles),
        .stat_aux_wait_cycles(stat_aux_wait_cycles),
        .stat_x0_drops(stat_x0_drops)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        l0_valid = 1'b0; l1_valid = 1'b0; md_valid = 1'b0; ld_valid = 1'b0;
        l0_rd = 5'd0; l1_rd = 5'd0; md_rd = 5'd0; ld_rd = 5'd0;
        l0_data = 32'd0; l1_data = 32'd0; md_data = 32'd0; ld_data = 32'd0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_we0", rf_we0, 1'b0);
        chk("rst_we1", rf_we1, 1'b0);
        chk("rst_waddr0", rf_waddr0, 5'd0);
        chk("rst_wdata1", rf_wdata1, 32'd0);
        chk("rst_stall", wb_stall, 1'b0);
        rst_n = 1'b1;
        tick();

        // two lanes, distinct rd
        l0_valid = 1'b1; l0_rd = 5'd3; l0_data = 32'hA;
        l1_valid = 1'b1; l1_rd = 5'd4; l1_data = 32'hB;
        #1;
        chk("lanes_md_ready", md_ready, 1'b0);
        tick();
        chk("lanes_we0", rf_we0, 1'b1);
        chk("lanes_waddr0", rf_waddr0, 5'd3);
        chk("lanes_wdata0", rf_wdata0, 32'hA);
        chk("lanes_we1", rf_we1, 1'b1);
        chk("lanes_waddr1", rf_waddr1, 5'd4);
        chk("lanes_wdata1", rf_wdata1, 32'hB);

        // same rd on both lanes: l1 wins
        l0_rd = 5'd5; l0_data = 32'h1;
        l1_rd = 5'd5; l1_data = 32'h2;
        tick();
        chk("same_we0", rf_we0, 1'b0);
        chk("same_we1", rf_we1, 1'b1);
        chk("same_waddr1", rf_waddr1, 5'd5);
        chk("same_wdata1", rf_wdata1, 32'h2);

        // l0 plus both aux, pointer at MD
        idle();
        l0_valid = 1'b1; l0_rd = 5'd7; l0_data = 32'h7;
        md_valid = 1'b1; md_rd = 5'd9;  md_data = 32'h99;
        ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 32'h1010;
        #1;
        chk("rr_md_ready", md_ready, 1'b1);
        chk("rr_ld_ready", ld_ready, 1'b0);
        tick();
        chk("rr_we0", rf_we0, 1'b1);
        chk("rr_waddr0", rf_waddr0, 5'd7);
        chk("rr_we1", rf_we1, 1'b1);
        chk("rr_waddr1", rf_waddr1, 5'd9);
        chk("rr_wdata1", rf_wdata1, 32'h99);

        // pointer now at LD: LD takes the single free port ahead of a new MD
        l0_rd = 5'd8; l0_data = 32'h8;
        md_rd = 5'd11; md_data = 32'h11;
        #1;
        chk("rr2_ld_ready", ld_ready, 1'b1);
        chk("rr2_md_ready", md_ready, 1'b0);
        tick();
        chk("rr2_waddr1", rf_waddr1, 5'd10);
        chk("rr2_wdata1", rf_wdata1, 32'h1010);
        chk("rr2_we1", rf_we1, 1'b1);

        // x0 destination consumes a port without writing
        idle();
        l0_valid = 1'b1; l0_rd = 5'd0; l0_data = 32'h55;
        l1_valid = 1'b1; l1_rd = 5'd6; l1_data = 32'h66;
        tick();
        chk("x0_we0", rf_we0, 1'b0);
        chk("x0_we1", rf_we1, 1'b1);
        chk("x0_waddr1", rf_waddr1, 5'd6);

        // MD starvation under full lane traffic
        idle();
        l0_valid = 1'b1; l0_rd = 5'd1; l0_data = 32'h1;
        l1_valid = 1'b1; l1_rd = 5'd2; l1_data = 32'h2;
        md_valid = 1'b1; md_rd = 5'd20; md_data = 32'h2020;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("starve_stall_c%0d", i), wb_stall, 1'b0);
            chk($sformatf("starve_ready_c%0d", i), md_ready, 1'b0);
            tick();
        end
        #1;
        chk("starve_stall_on", wb_stall, 1'b1);
        chk("starve_md_ready", md_ready, 1'b1);
        tick();
        chk("starve_we0", rf_we0, 1'b1);
        chk("starve_waddr0", rf_waddr0, 5'd20);
        chk("starve_wdata0", rf_wdata0, 32'h2020);
        chk("starve_we1_masked", rf_we1, 1'b0);
        chk("starve_stall_off", wb_stall, 1'b0);

        // load collides with lane 1 destination
        idle();
        l1_valid = 1'b1; l1_rd = 5'd12; l1_data = 32'hC1;
        ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'hCC;
        #1;
        chk("conf_ld_ready", ld_ready, 1'b0);
        tick();
        chk("conf_we0", rf_we0, 1'b1);
        chk("conf_waddr0", rf_waddr0, 5'd12);
        chk("conf_wdata0", rf_wdata0, 32'hC1);
        chk("conf_we1", rf_we1, 1'b0);
        l1_valid = 1'b0;
        #1;
        chk("conf_ld_ready2", ld_ready, 1'b1);
        tick();
        chk("conf_ld_waddr0", rf_waddr0, 5'd12);
        chk("conf_ld_wdata0", rf_wdata0, 32'hCC);
        chk("conf_ld_we1", rf_we1, 1'b0);

        // reset during a stall with MD pending
        idle();
        l0_valid = 1'b1; l0_rd = 5'd1; l0_data = 32'h1;
        l1_valid = 1'b1; l1_rd = 5'd2; l1_data = 32'h2;
        md_valid = 1'b1; md_rd = 5'd20; md_data = 32'h2020;
        for (int i = 0; i < 8; i++) tick();
        #1;
        chk("rst2_pre_stall", wb_stall, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst2_we0", rf_we0, 1'b0);
        chk("rst2_we1", rf_we1, 1'b0);
        chk("rst2_stall", wb_stall, 1'b0);
        chk("rst2_md_cnt", dut.md_wait, 8'd0);
        tick();
        chk("rst2_hold_we0", rf_we0, 1'b0);
        l0_valid = 1'b0;
        l1_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rst2_md_ready", md_ready, 1'b1);
        tick();
        chk("rst2_fresh_we0", rf_we0, 1'b1);
        chk("rst2_fresh_waddr0", rf_waddr0, 5'd20);
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
